// File: rtl/mu_seq.sv
// mu_seq: issue/retire controller for a fixed-latency, free-running multiply unit.
//
// Requests are admitted on a valid/ready handshake only while a result FIFO
// slot is guaranteed (in-flight ops plus queued results below DEPTH), so a
// retiring result can never meet a full FIFO. A LAT-stage tag shift register
// follows each op through the multiplier; when its valid bit reaches the last
// stage, mu_res is captured with the destination tag into the result FIFO.
// Results are returned strictly in issue order.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous kill of all in-flight and queued ops
//   req_valid/req_ready   request handshake
//   req_a, req_b          operands
//   req_mulctl            00 mul, 01 mulh, 10 mulhsu, 11 mulhu
//   req_rd                destination register tag
//   mu_a, mu_b, mu_mulctl operands/control to the multiply unit (0 when idle)
//   mu_res                multiply unit result
//   rsp_valid/rsp_ready   result handshake
//   rsp_data, rsp_rd      FIFO head result and destination tag
//   busy                  any op in flight or queued
module mu_seq #(
  parameter int unsigned LAT   = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RDW   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [31:0]    req_a,
  input  logic [31:0]    req_b,
  input  logic [1:0]     req_mulctl,
  input  logic [RDW-1:0] req_rd,
  output logic [31:0]    mu_a,
  output logic [31:0]    mu_b,
  output logic [1:0]     mu_mulctl,
  input  logic [31:0]    mu_res,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [31:0]    rsp_data,
  output logic [RDW-1:0] rsp_rd,
  output logic           busy
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [LAT-1:0] tag_v;
  logic [RDW-1:0] tag_rd [LAT];

  logic [CW-1:0]  inflight;
  logic [CW-1:0]  fifo_count;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [31:0]    mem_data [DEPTH];
  logic [RDW-1:0] mem_rd   [DEPTH];

  logic           accept;
  logic           retire;
  logic           rd_en;
  logic [CW:0]    credit_used;

  // Credits: every in-flight op already owns a FIFO slot.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign req_ready   = !flush && (credit_used < (CW+1)'(DEPTH));
  assign accept      = req_valid & req_ready;
  assign retire      = tag_v[LAT-1];

  assign mu_a      = accept ? req_a      : '0;
  assign mu_b      = accept ? req_b      : '0;
  assign mu_mulctl = accept ? req_mulctl : '0;

  assign rsp_valid = (fifo_count != '0);
  assign rd_en     = rsp_valid & rsp_ready;
  assign rsp_data  = mem_data[rd_ptr];
  assign rsp_rd    = mem_rd[rd_ptr];
  assign busy      = (inflight != '0) | (fifo_count != '0);

  // Tag pipeline, aligned with the multiply unit's internal stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int unsigned i = 0; i < LAT; i++) tag_rd[i] <= '0;
    end else begin
      if (flush) tag_v <= '0;
      else       tag_v <= {tag_v[LAT-2:0], accept};
      tag_rd[0] <= req_rd;
      for (int unsigned i = 1; i < LAT; i++) tag_rd[i] <= tag_rd[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     inflight <= '0;
    else if (flush) inflight <= '0;
    else            inflight <= inflight + CW'(accept) - CW'(retire);
  end

  // Result FIFO. On a simultaneous read and write while full, wr_ptr equals
  // rd_ptr: the head being consumed is overwritten by the new tail at the
  // same edge, which keeps order since rd_ptr advances past it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_rd[i]   <= '0;
      end
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (retire) begin
        mem_data[wr_ptr] <= mu_res;
        mem_rd[wr_ptr]   <= tag_rd[LAT-1];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(retire) - CW'(rd_en);
    end
  end

  no_retire_into_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(retire && (fifo_count == CW'(DEPTH)) && !rd_en));

endmodule

// File: tb/tb_mu_seq.sv
// Bench for mu_seq: a behavioural LAT-stage multiply unit feeds mu_res; a
// driver issues directed requests and pushes hand-computed results into a
// scoreboard queue on acceptance; an independent monitor pops and compares
// whenever a result handshake completes.
module tb_mu_seq;
  localparam int unsigned LAT   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RDW   = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [31:0]    req_a = '0;
  logic [31:0]    req_b = '0;
  logic [1:0]     req_mulctl = '0;
  logic [RDW-1:0] req_rd = '0;
  logic [31:0]    mu_a;
  logic [31:0]    mu_b;
  logic [1:0]     mu_mulctl;
  logic [31:0]    mu_res;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [31:0]    rsp_data;
  logic [RDW-1:0] rsp_rd;
  logic           busy;

  always #5 clk = ~clk;

  mu_seq #(.LAT(LAT), .DEPTH(DEPTH), .RDW(RDW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mulctl(req_mulctl), .req_rd(req_rd),
    .mu_a(mu_a), .mu_b(mu_b), .mu_mulctl(mu_mulctl), .mu_res(mu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_rd(rsp_rd), .busy(busy)
  );

  // Free-running multiply unit, never reset.
  function automatic logic [31:0] mul_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] c);
    logic [63:0] p;
    logic [31:0] r;
    case (c)
      2'b00:   begin p = {32'b0, a} * {32'b0, b};             r = p[31:0];  end
      2'b01:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      2'b10:   begin p = {{32{a[31]}}, a} * {32'b0, b};       r = p[63:32]; end
      default: begin p = {32'b0, a} * {32'b0, b};             r = p[63:32]; end
    endcase
    return r;
  endfunction

  logic [31:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_f(mu_a, mu_b, mu_mulctl);
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mu_res = mpipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [36:0] sb [$];
  int          pop_cyc [$];
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Monitor: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {27'b0, rsp_rd, rsp_data}, 64'hDEAD);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e[31:0]);
        chk("rsp_rd", rsp_rd, e[36:32]);
      end
      pop_cyc.push_back(cyc);
    end
  end

  // All driver tasks are entered and left 1ns after a rising edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                      input logic [RDW-1:0] rd, input logic [31:0] exp);
    bit done = 0;
    req_valid = 1'b1; req_a = a; req_b = b; req_mulctl = c; req_rd = rd;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (req_ready) begin
        chk("mu_a", mu_a, a);
        chk("mu_mulctl", mu_mulctl, c);
        sb.push_back({rd, exp});
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 0, 1);
    req_valid = 1'b0; req_a = '0; req_b = '0; req_mulctl = '0; req_rd = '0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200; t++) begin
      if (sb.size() == 0 && !busy) break;
      @(posedge clk); #1;
    end
    chk("drain", {sb.size() == 0, busy}, 2'b10);
  endtask

  logic [31:0]    va   [6] = '{32'd5, 32'hFFFFFFFF, 32'h00010000, 32'h80000000, 32'h12345678, 32'hFFFFFFFF};
  logic [31:0]    vb   [6] = '{32'd7, 32'hFFFFFFFF, 32'h00010000, 32'h00000002, 32'h00000010, 32'hFFFFFFFF};
  logic [1:0]     vc   [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00};
  logic [RDW-1:0] vrd  [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7};
  logic [31:0]    vexp [6] = '{32'h23, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h23456780, 32'h1};
  int idx = 0;

  // Holds req_valid high across the vector table, advancing on each accept.
  task automatic stream(input int ncyc);
    for (int t = 0; t < ncyc; t++) begin
      if (idx < 6) begin
        req_valid = 1'b1; req_a = va[idx]; req_b = vb[idx];
        req_mulctl = vc[idx]; req_rd = vrd[idx];
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      if (req_valid && req_ready) begin
        sb.push_back({vrd[idx], vexp[idx]});
        idx++;
      end else if (req_valid) begin
        chk("mu_idle_a", mu_a, 0);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int n;
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_rd", rsp_rd, 0);
    chk("rst_mu_a", mu_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single op, exact latency
    rsp_ready = 1'b1;
    send(32'd3, 32'hFFFFFFFE, 2'b00, 5'd5, 32'hFFFFFFFA);
    repeat (LAT) begin
      @(negedge clk);
      chk("lat_early_valid", rsp_valid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("lat_valid", rsp_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_after_pop", busy, 0);
    @(posedge clk); #1;

    // Back-to-back, consecutive results
    n = pop_cyc.size();
    send(32'h80000000, 32'h80000000, 2'b01, 5'd20, 32'h40000000);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 5'd21, 32'hFFFFFFFE);
    send(32'hFFFFFFFF, 32'h00000002, 2'b10, 5'd22, 32'hFFFFFFFF);
    wait_drain();
    if (pop_cyc.size() >= n + 3) begin
      chk("b2b_gap1", pop_cyc[n+1] - pop_cyc[n], 1);
      chk("b2b_gap2", pop_cyc[n+2] - pop_cyc[n+1], 1);
    end else begin
      chk("b2b_count", pop_cyc.size() - n, 3);
    end

    // Back-pressure: exactly DEPTH accepts, then release
    rsp_ready = 1'b0;
    idx = 0;
    stream(20);
    chk("bp_accepts", idx, DEPTH);
    @(negedge clk);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_mu_idle", mu_a, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    stream(40);
    chk("bp_all_accepted", idx, 6);
    wait_drain();

    // Pop and retire at the same edge with the credit limit reached
    rsp_ready = 1'b0;
    send(32'd2, 32'd3, 2'b00, 5'd8, 32'd6);
    send(32'd4, 32'd5, 2'b00, 5'd9, 32'h14);
    send(32'd10, 32'd10, 2'b00, 5'd10, 32'h64);
    repeat (LAT + 1) @(posedge clk);
    #1;
    @(negedge clk);
    chk("q3_req_ready", req_ready, 1);
    @(posedge clk); #1;
    send(32'hFFFFFFFF, 32'd2, 2'b11, 5'd11, 32'd1);
    @(negedge clk);
    chk("q3_credit_full", req_ready, 0);
    repeat (LAT - 1) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("q3_pre_ready", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("q3_post_ready", req_ready, 1);
    chk("q3_post_valid", rsp_valid, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain();

    // Flush with one queued and three in flight
    rsp_ready = 1'b0;
    send(32'd1, 32'd1, 2'b00, 5'd12, 32'd1);
    repeat (LAT + 1) @(posedge clk);
    #1;
    send(32'd2, 32'd2, 2'b00, 5'd15, 32'd4);
    send(32'd3, 32'd3, 2'b00, 5'd23, 32'd9);
    send(32'd4, 32'd4, 2'b00, 5'd24, 32'd16);
    flush = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("fl_req_ready", req_ready, 0);
    chk("fl_busy_before", busy, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fl_rsp_valid", rsp_valid, 0);
    chk("fl_busy", busy, 0);
    chk("fl_req_ready_after", req_ready, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(32'd7, 32'd6, 2'b00, 5'd13, 32'd42);
    wait_drain();

    // Asynchronous reset mid-stream
    rsp_ready = 1'b0;
    send(32'd5, 32'd5, 2'b00, 5'd16, 32'd25);
    send(32'd6, 32'd6, 2'b00, 5'd17, 32'd36);
    repeat (LAT + 1) @(posedge clk);
    #1;
    send(32'd8, 32'd8, 2'b00, 5'd18, 32'd64);
    send(32'd9, 32'd9, 2'b00, 5'd19, 32'd81);
    @(negedge clk);
    chk("ar_pre_valid", rsp_valid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("ar_rsp_valid", rsp_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_rsp_data", rsp_data, 0);
    chk("ar_rsp_rd", rsp_rd, 0);
    chk("ar_req_ready", req_ready, 1);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (2 * LAT) @(posedge clk);
    #1;
    chk("ar_no_stale", {rsp_valid, busy}, 2'b00);
    send(32'h100, 32'h100, 2'b00, 5'd14, 32'h10000);
    wait_drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
